// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and small op-decoding helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add for multiply, restoring
// trial-subtract-shift for divide. Purely combinational.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Multiply: {hi,lo} holds the partial product over the remaining multiplier
    // bits. Divide: hi is the partial remainder, lo shifts dividend out and
    // quotient in. The extra bit in w_diff is the borrow of the trial subtract.
    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_hi, i_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_opnd};
        if (i_is_div) begin
            if (!w_diff[WIDTH]) begin
                o_hi = w_diff[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shift[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// One datapath step per cycle; result and done land WIDTH+1 edges after start.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       r_state;
    mdu_op_e          r_op;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    logic               w_in_signed;
    logic               w_in_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_run_div;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Operand magnitudes and sign flags are taken from the live inputs and
    // captured at start; a/b are free to change while the operation runs.
    assign w_in_signed = is_signed_op(op);
    assign w_in_div    = is_div_op(op);
    assign w_a_neg     = w_in_signed & a[WIDTH-1];
    assign w_b_neg     = w_in_signed & b[WIDTH-1];
    assign w_a_abs     = w_a_neg ? -a : a;
    assign w_b_abs     = w_b_neg ? -b : b;
    assign w_run_div   = is_div_op(r_op);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (w_run_div),
        .i_hi     (r_acc_hi),
        .i_lo     (r_acc_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // r_neg_q doubles as the product sign flag for multiplies.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem      = r_neg_r ? -r_acc_hi : r_acc_hi;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= MDU_MULT;
            r_count  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_zero   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (start) begin
                        r_op     <= mdu_op_e'(op);
                        r_count  <= '0;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_in_div ? w_a_abs : w_b_abs;
                        r_opnd   <= w_in_div ? w_b_abs : w_a_abs;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_zero   <= w_in_div && (b == '0);
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_count  <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) r_state <= FIX;
                end
                FIX: begin
                    if (!w_run_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (!r_zero) begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end
                    r_done  <= 1'b1;
                    r_dz    <= r_zero;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus random ops checked
// against an arithmetic reference model of HI/LO.
module tb_mdu_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          mthi;
    logic          mtlo;
    logic [W-1:0]  wdata;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;

    mdu_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: HI/LO straight from 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                  output logic [31:0] e_hi, output logic [31:0] e_lo,
                                  output logic e_dz);
        longint          sp;
        longint          sq;
        longint          sr;
        longint unsigned up;
        e_hi = cur_hi;
        e_lo = cur_lo;
        e_dz = 1'b0;
        case (o)
            2'b00: begin
                sp   = longint'($signed(x)) * longint'($signed(y));
                e_hi = sp[63:32];
                e_lo = sp[31:0];
            end
            2'b01: begin
                up   = {32'd0, x} * {32'd0, y};
                e_hi = up[63:32];
                e_lo = up[31:0];
            end
            2'b10: begin
                if (y == 32'd0) e_dz = 1'b1;
                else begin
                    sq   = longint'($signed(x)) / longint'($signed(y));
                    sr   = longint'($signed(x)) % longint'($signed(y));
                    e_lo = sq[31:0];
                    e_hi = sr[31:0];
                end
            end
            default: begin
                if (y == 32'd0) e_dz = 1'b1;
                else begin
                    e_lo = x / y;
                    e_hi = x % y;
                end
            end
        endcase
    endfunction

    // Called at a falling edge with the unit idle; returns at the falling edge
    // where done is observed, so a following call starts in the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit mv);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dz;
        int          busy_cnt;
        bit          seen;
        if (mv) begin
            m_hi = 32'h0000AAAA;
            m_lo = 32'h0000AAAA;
        end
        model(o, x, y, m_hi, m_lo, e_hi, e_lo, e_dz);
        start = 1'b1; op = o; a = x; b = y;
        mthi = mv; mtlo = mv; wdata = 32'h0000AAAA;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = $urandom; b = $urandom;
        check("busy_after_start", busy, 1);
        check("done_single_pulse", done, 0);
        if (mv) begin
            check("mv_with_start_hi", hi, 32'h0000AAAA);
            check("mv_with_start_lo", lo, 32'h0000AAAA);
        end
        busy_cnt = 1;
        seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        check("done_seen", seen, 1);
        check("busy_cycles", busy_cnt, W + 1);
        check("busy_low_at_done", busy, 0);
        check("hi", hi, e_hi);
        check("lo", lo, e_lo);
        check("div_by_zero", div_by_zero, e_dz);
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic move_to(input bit h, input bit l, input logic [31:0] d);
        mthi = h; mtlo = l; wdata = d;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        check("move_hi", hi, m_hi);
        check("move_lo", lo, m_lo);
    endtask

    initial begin
        logic [31:0] ext [4];
        int          n_done;
        bit          seen;
        ext = '{32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        do_op(2'b00, 32'd7, 32'hFFFFFFFD, 1'b0);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFEB);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check("multu_max_hi", hi, 32'hFFFFFFFE);
        check("multu_max_lo", lo, 32'h00000001);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);

        @(negedge clk);
        move_to(1'b1, 1'b0, 32'h1234);
        move_to(1'b0, 1'b1, 32'h5678);
        do_op(2'b11, 32'd10, 32'd0, 1'b0);
        check("dz_flag", div_by_zero, 1);
        check("dz_hi_kept", hi, 32'h1234);
        check("dz_lo_kept", lo, 32'h5678);

        // Start and move-to while busy must both be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9; mthi = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("busy_mthi_ignored", hi, 32'h1234);
        n_done = 0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("busy_single_done", n_done, 1);
        check("busy_hi", hi, 32'h0);
        check("busy_lo", lo, 32'd15);
        m_hi = 32'h0;
        m_lo = 32'd15;

        // Reset in the middle of a DIVU abandons it.
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 15'd0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", seen, 0);
        m_hi = '0;
        m_lo = '0;
        do_op(2'b11, 32'd1000, 32'd7, 1'b0);
        do_op(2'b01, 32'd2, 32'd3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            int          k;
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            k  = int'($urandom_range(0, 4));
            case (k)
                1: ry = '0;
                2: begin
                    rx = 32'($urandom_range(0, 200)) - 32'd100;
                    ry = 32'($urandom_range(0, 20)) - 32'd10;
                end
                3: begin
                    rx = ext[$urandom_range(0, 3)];
                    ry = ext[$urandom_range(0, 3)];
                end
                4: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clk);
                move_to($urandom_range(0, 1) == 1, 1'b1, $urandom);
            end
            do_op(ro, rx, ry, $urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        check("final_done_low", done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Iterative multiply/divide unit in the execute stage, fed the same rs/rt operands as the ALU.
- Implements MULT, MULTU, DIV and DIVU into HI/LO registers, plus MTHI/MTLO writes.
- HI/LO are always visible to the writeback mux for MFHI/MFLO.
- The controller stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  launch operation; sampled only when idle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
mthi  input  1  write wdata to HI; honoured only when idle
mtlo  input  1  write wdata to LO; honoured only when idle
wdata  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
div_by_zero  output  1  one-cycle pulse with done when a DIV/DIVU had b==0

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Internal accumulators and counter cleared.
  - Reset mid-operation abandons the operation; no done is produced.
- States:
  - IDLE: start=1 captures op, |a|, |b| (absolute values for signed ops; raw for unsigned) and sign info; count=0; -> RUN; busy=1 from the next cycle.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, WIDTH cycles; count increments; at count==WIDTH-1 -> FIX.
  - FIX:
    - Applies sign correction and writes HI/LO.
    - Pulses done=1 (and div_by_zero if applicable) in the following cycle.
    - busy=0 in that same cycle; -> IDLE.
- Latency:
  - start accepted at edge E0.
  - HI/LO updated and done=1 after edge E(WIDTH+1), i.e. 33 edges for WIDTH=32.
  - busy is high for exactly WIDTH+1 cycles.
- Multiply:
  - 2*WIDTH-bit product; HI=upper half, LO=lower half.
  - Signed: product negated (two's complement, 2*WIDTH bits) when sign(a)!=sign(b).
- Divide:
  - LO=quotient, HI=remainder.
  - Signed: quotient negated when signs differ; remainder takes the sign of the dividend.
  - -2^31 / -1 yields LO=0x80000000, HI=0 (no trap).
- Divide by zero:
  - Runs full latency.
  - HI/LO left unchanged.
  - div_by_zero=1 alongside done.
- start while busy: ignored, no queueing.
- start in the done cycle: legal, since state is IDLE.
- mthi/mtlo:
  - Write on the clock edge when state==IDLE; ignored while busy.
  - mthi and mtlo together write both registers.
  - Together with start: the move-to writes land; the later operation result overwrites them.
- Outputs hi/lo are registered and hold their value except on FIX or a move-to write.
- done and div_by_zero are registered single-cycle pulses.

Decomposition:
- Shared package holds:
  - op encodings: MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - State encoding: IDLE, RUN, FIX.
  - WIDTH default.
- One natural sub-module: mdu_step.
  - Combinational single-iteration datapath: add-shift for multiply, trial-subtract-shift for divide.
  - Selected by an is_div bit.
  - FSM, counter, sign handling and HI/LO stay in mdu_unit.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3), start one cycle -> busy high 33 cycles; done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI wdata=0x1234, MTLO wdata=0x5678, then DIVU a=10, b=0 -> done with div_by_zero=1; HI=0x1234, LO=0x5678 unchanged.
- Busy interference:
  - start MULTU 3*5.
  - Pulse start (MULTU 9*9) and mthi (wdata=0xDEAD) at cycle 10.
  - Required: both ignored; final HI=0, LO=15; single done pulse.
- Reset mid-run: assert reset at cycle 12 of a DIVU -> immediate hi=lo=0, busy=0; no done. A new start after release completes normally.
